// File: rtl/retire_load_queue_pkg.sv
// rtl/retire_load_queue_pkg.sv - shared types and helpers for the load retire queue
package retire_load_queue_pkg;

  typedef enum logic [4:0] {
    NOP, LUI, ADD, SUB,
    LB, LBU, LH, LHU, LW, LR_W, SC_W,
    SB, SH, SW
  } iType_e;

  typedef enum logic [1:0] {
    AMO_OFF, AMO_ZALRSC, AMO_ZAAMO, AMO_A
  } atomic_e;

  typedef struct packed {
    iType_e      op;
    logic [4:0]  rd;
    logic [31:0] addr;
  } load_entry_t;

  function automatic logic is_load(input iType_e op);
    return op inside {LB, LBU, LH, LHU, LW, LR_W};
  endfunction

endpackage

// File: rtl/retire_load_queue_aligner.sv
// rtl/retire_load_queue_aligner.sv - byte/half/word selection and extension of a load response
module load_aligner
  import retire_load_queue_pkg::*;
(
  input  iType_e      op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (op)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data = {24'b0, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LHU:     data = {16'b0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/retire_load_queue.sv
// rtl/retire_load_queue.sv - in-order load retire queue, regbank write-back, LR/SC reservation
// Optional reservation lifetime limit: RS5_RES_TIMEOUT_EN
module retire_load_queue
  import retire_load_queue_pkg::*;
#(
  parameter int      DEPTH       = 2,
  parameter atomic_e AMOEXT      = AMO_A,
  parameter int      RES_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  iType_e      instruction_operation_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] result_i,
  input  logic        flush_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_data_i,
  output logic        regbank_we_o,
  output logic [4:0]  regbank_addr_o,
  output logic [31:0] regbank_data_o,
  output logic        reservation_valid_o,
  output logic [31:0] reservation_addr_o,
  output logic [31:0] reservation_data_o,
  output logic        spurious_rsp_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

`ifndef RS5_RES_TIMEOUT_EN
  localparam int unused_res_timeout = RES_TIMEOUT;
`endif

  load_entry_t      entries [DEPTH];
  logic [DEPTH-1:0] killed;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  load_entry_t head;
  logic [31:0] aligned;
  logic        incoming_load, can_accept, accept, push, pop;
  logic        retire_ok, lr_retire, sc_accept, res_expire;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head          = entries[rd_ptr];
  assign incoming_load = is_load(instruction_operation_i);
  assign pop           = mem_rvalid_i && (count != '0);
  // A full queue still takes a load when the head retires in the same cycle.
  assign can_accept    = incoming_load ? ((count < CW'(DEPTH)) || pop) : (count == '0);
  assign instr_ready_o = reset_n && can_accept;
  assign accept        = instr_valid_i && instr_ready_o;
  assign push          = accept && incoming_load;
  assign retire_ok     = pop && !killed[rd_ptr] && !flush_i;
  assign lr_retire     = retire_ok && (head.op == LR_W);
  assign sc_accept     = accept && (instruction_operation_i == SC_W);

  load_aligner u_aligner (
    .op     (head.op),
    .offset (head.addr[1:0]),
    .word   (mem_data_i),
    .data   (aligned)
  );

  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= '{op: instruction_operation_i, rd: rd_i, addr: result_i};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      killed <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
      if (flush_i)   killed <= '1;
      else if (push) killed[wr_ptr] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regbank_we_o   <= 1'b0;
      regbank_addr_o <= '0;
      regbank_data_o <= '0;
      spurious_rsp_o <= 1'b0;
    end else begin
      regbank_we_o   <= 1'b0;
      spurious_rsp_o <= mem_rvalid_i && (count == '0);
      if (pop) begin
        regbank_we_o   <= retire_ok && (head.rd != '0);
        regbank_addr_o <= head.rd;
        regbank_data_o <= aligned;
      end else if (accept && !incoming_load) begin
        regbank_we_o   <= !flush_i && (rd_i != '0);
        regbank_addr_o <= rd_i;
        regbank_data_o <= result_i;
      end
    end
  end

  generate
    if (AMOEXT == AMO_A || AMOEXT == AMO_ZALRSC) begin : g_res
`ifdef RS5_RES_TIMEOUT_EN
      logic [31:0] res_age;
      assign res_expire = reservation_valid_o && (res_age == 32'(RES_TIMEOUT - 1));
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 res_age <= '0;
        else if (lr_retire)           res_age <= '0;
        else if (reservation_valid_o) res_age <= res_age + 32'd1;
      end
`else
      assign res_expire = 1'b0;
`endif
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          reservation_valid_o <= 1'b0;
          reservation_addr_o  <= '0;
          reservation_data_o  <= '0;
        end else if (lr_retire) begin
          reservation_valid_o <= 1'b1;
          reservation_addr_o  <= {head.addr[31:2], 2'b00};
          reservation_data_o  <= aligned;
        end else if (sc_accept || res_expire) begin
          reservation_valid_o <= 1'b0;
          reservation_addr_o  <= '0;
          reservation_data_o  <= '0;
        end
      end
    end else begin : g_no_res
      assign res_expire          = 1'b0;
      assign reservation_valid_o = 1'b0;
      assign reservation_addr_o  = '0;
      assign reservation_data_o  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_retire_load_queue.sv
// tb/tb_retire_load_queue.sv - self-checking bench for retire_load_queue
module tb_retire_load_queue;
  import retire_load_queue_pkg::*;

  localparam int DEPTH       = 2;
  localparam int RES_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid_i, instr_ready_o, flush_i, mem_rvalid_i;
  iType_e      instruction_operation_i;
  logic [4:0]  rd_i, regbank_addr_o;
  logic [31:0] result_i, mem_data_i, regbank_data_o;
  logic        regbank_we_o, reservation_valid_o, spurious_rsp_o;
  logic [31:0] reservation_addr_o, reservation_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  retire_load_queue #(.DEPTH(DEPTH), .AMOEXT(AMO_A), .RES_TIMEOUT(RES_TIMEOUT)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .instr_valid_i           (instr_valid_i),
    .instr_ready_o           (instr_ready_o),
    .instruction_operation_i (instruction_operation_i),
    .rd_i                    (rd_i),
    .result_i                (result_i),
    .flush_i                 (flush_i),
    .mem_rvalid_i            (mem_rvalid_i),
    .mem_data_i              (mem_data_i),
    .regbank_we_o            (regbank_we_o),
    .regbank_addr_o          (regbank_addr_o),
    .regbank_data_o          (regbank_data_o),
    .reservation_valid_o     (reservation_valid_o),
    .reservation_addr_o      (reservation_addr_o),
    .reservation_data_o      (reservation_data_o),
    .spurious_rsp_o          (spurious_rsp_o)
  );

  typedef struct {
    iType_e      op;
    logic [4:0]  rd;
    logic [31:0] addr;
    bit          killed;
  } m_entry_t;

  // Reference load extension: shift the word down to the addressed lane, mask, extend.
  function automatic logic [31:0] ref_load(input iType_e op, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * addr[1:0]);
    case (op)
      LB:      return (v & 32'hFF)   | (((v & 32'h80) != 0)   ? 32'hFFFF_FF00 : 32'h0);
      LBU:     return  v & 32'hFF;
      LH:      return (v & 32'hFFFF) | (((v & 32'h8000) != 0) ? 32'hFFFF_0000 : 32'h0);
      LHU:     return  v & 32'hFFFF;
      default: return word;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input iType_e op, input logic [4:0] rd, input logic [31:0] val);
    instr_valid_i = 1'b1;
    instruction_operation_i = op;
    rd_i = rd;
    result_i = val;
    tick();
    instr_valid_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rvalid_i = 1'b1;
    mem_data_i = d;
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    instr_valid_i = 1'b0; flush_i = 1'b0; mem_rvalid_i = 1'b0;
    instruction_operation_i = NOP; rd_i = '0; result_i = '0; mem_data_i = '0;
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({instr_ready_o, regbank_we_o, reservation_valid_o, spurious_rsp_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {instr_ready_o, regbank_we_o, reservation_valid_o, spurious_rsp_o});
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (instr_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", instr_ready_o);
    end
  endtask

  task automatic test_align();
    logic [31:0] a, d, exp_d;
    logic [4:0]  r;
    iType_e      op;
    iType_e      ops [5] = '{LB, LBU, LH, LHU, LW};
    issue(LB, 5'd5, 32'h0000_0103);
    respond(32'h8012_3456);
    n_checks++;
    if ({regbank_we_o, regbank_addr_o, regbank_data_o} !== {1'b1, 5'd5, 32'hFFFF_FF80}) begin
      n_fail++; $display("FAIL align_lb: got %b %0d %h expected 1 5 ffffff80",
                         regbank_we_o, regbank_addr_o, regbank_data_o);
    end
    issue(LHU, 5'd6, 32'h0000_0102);
    respond(32'h8012_3456);
    n_checks++;
    if ({regbank_we_o, regbank_addr_o, regbank_data_o} !== {1'b1, 5'd6, 32'h0000_8012}) begin
      n_fail++; $display("FAIL align_lhu: got %b %0d %h expected 1 6 00008012",
                         regbank_we_o, regbank_addr_o, regbank_data_o);
    end
    for (int i = 0; i < 16; i++) begin
      op = ops[$urandom_range(0, 4)];
      a  = $urandom;
      if (op == LH || op == LHU) a[0] = 1'b0;
      r  = 5'($urandom_range(0, 31));
      d  = $urandom;
      exp_d = ref_load(op, a, d);
      issue(op, r, a);
      respond(d);
      n_checks++;
      if (regbank_we_o !== (r != 0) || (r != 0 && (regbank_addr_o !== r || regbank_data_o !== exp_d))) begin
        n_fail++; $display("FAIL align_rand op=%s addr=%h: got %b %0d %h expected %b %0d %h",
                           op.name(), a, regbank_we_o, regbank_addr_o, regbank_data_o,
                           (r != 0), r, exp_d);
      end
    end
  endtask

  task automatic test_full();
    issue(LW, 5'd5, 32'h200);
    issue(LW, 5'd6, 32'h204);
    instr_valid_i = 1'b1; instruction_operation_i = LW; rd_i = 5'd7; result_i = 32'h208;
    #1;
    n_checks++;
    if (instr_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL full_stall: got %b expected 0", instr_ready_o);
    end
    tick();
    n_checks++;
    if (instr_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL full_stall_hold: got %b expected 0", instr_ready_o);
    end
    mem_rvalid_i = 1'b1; mem_data_i = 32'h1111_0005;
    #1;
    n_checks++;
    if (instr_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL full_pushpop_ready: got %b expected 1", instr_ready_o);
    end
    tick();
    instr_valid_i = 1'b0; mem_rvalid_i = 1'b0;
    n_checks++;
    if ({regbank_we_o, regbank_addr_o, regbank_data_o} !== {1'b1, 5'd5, 32'h1111_0005}) begin
      n_fail++; $display("FAIL full_wb_r5: got %b %0d %h expected 1 5 11110005",
                         regbank_we_o, regbank_addr_o, regbank_data_o);
    end
    #1;
    n_checks++;
    if (instr_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL full_count_kept: got %b expected 0", instr_ready_o);
    end
    respond(32'h2222_0006);
    n_checks++;
    if ({regbank_we_o, regbank_addr_o, regbank_data_o} !== {1'b1, 5'd6, 32'h2222_0006}) begin
      n_fail++; $display("FAIL full_wb_r6: got %b %0d %h expected 1 6 22220006",
                         regbank_we_o, regbank_addr_o, regbank_data_o);
    end
    respond(32'h3333_0007);
    n_checks++;
    if ({regbank_we_o, regbank_addr_o, regbank_data_o} !== {1'b1, 5'd7, 32'h3333_0007}) begin
      n_fail++; $display("FAIL full_wb_r7: got %b %0d %h expected 1 7 33330007",
                         regbank_we_o, regbank_addr_o, regbank_data_o);
    end
    n_checks++;
    if (instr_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL full_drained_ready: got %b expected 1", instr_ready_o);
    end
  endtask

  task automatic test_order();
    issue(LW, 5'd4, 32'h300);
    instr_valid_i = 1'b1; instruction_operation_i = ADD; rd_i = 5'd3; result_i = 32'h1234;
    #1;
    n_checks++;
    if (instr_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL order_add_stall: got %b expected 0", instr_ready_o);
    end
    tick();
    respond(32'hABCD_0123);
    n_checks++;
    if ({regbank_we_o, regbank_addr_o, regbank_data_o} !== {1'b1, 5'd4, 32'hABCD_0123}) begin
      n_fail++; $display("FAIL order_load_first: got %b %0d %h expected 1 4 abcd0123",
                         regbank_we_o, regbank_addr_o, regbank_data_o);
    end
    n_checks++;
    if (instr_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL order_add_ready: got %b expected 1", instr_ready_o);
    end
    tick();
    instr_valid_i = 1'b0;
    n_checks++;
    if ({regbank_we_o, regbank_addr_o, regbank_data_o} !== {1'b1, 5'd3, 32'h0000_1234}) begin
      n_fail++; $display("FAIL order_add_wb: got %b %0d %h expected 1 3 00001234",
                         regbank_we_o, regbank_addr_o, regbank_data_o);
    end
  endtask

  task automatic test_flush();
    issue(LW, 5'd8, 32'h400);
    issue(LW, 5'd9, 32'h404);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      respond(32'h5555_0000 + 32'(i));
      n_checks++;
      if ({regbank_we_o, spurious_rsp_o} !== 2'b00) begin
        n_fail++; $display("FAIL flush_no_wb%0d: got %b expected 00", i, {regbank_we_o, spurious_rsp_o});
      end
    end
    instruction_operation_i = ADD;
    #1;
    n_checks++;
    if (instr_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_empty_ready: got %b expected 1", instr_ready_o);
    end
  endtask

  task automatic test_spurious();
    respond(32'hDEAD_BEEF);
    n_checks++;
    if ({spurious_rsp_o, regbank_we_o} !== 2'b10) begin
      n_fail++; $display("FAIL spurious_pulse: got %b expected 10", {spurious_rsp_o, regbank_we_o});
    end
    tick();
    n_checks++;
    if (spurious_rsp_o !== 1'b0) begin
      n_fail++; $display("FAIL spurious_one_cycle: got %b expected 0", spurious_rsp_o);
    end
  endtask

  task automatic test_reservation();
    issue(LR_W, 5'd10, 32'h1006);
    respond(32'hCAFE_F00D);
    n_checks++;
    if ({reservation_valid_o, reservation_addr_o, reservation_data_o} !== {1'b1, 32'h1004, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL res_set: got %b %h %h expected 1 00001004 cafef00d",
                         reservation_valid_o, reservation_addr_o, reservation_data_o);
    end
    issue(SC_W, 5'd11, 32'h0);
    n_checks++;
    if ({reservation_valid_o, reservation_addr_o, reservation_data_o} !== {1'b0, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL res_sc_clear: got %b %h %h expected 0 0 0",
                         reservation_valid_o, reservation_addr_o, reservation_data_o);
    end
    n_checks++;
    if ({regbank_we_o, regbank_addr_o} !== {1'b1, 5'd11}) begin
      n_fail++; $display("FAIL res_sc_wb: got %b %0d expected 1 11", regbank_we_o, regbank_addr_o);
    end
    issue(LR_W, 5'd12, 32'h2000);
    respond(32'h0BAD_CAFE);
`ifdef RS5_RES_TIMEOUT_EN
    for (int i = 1; i < RES_TIMEOUT; i++) begin
      tick();
      n_checks++;
      if (reservation_valid_o !== 1'b1) begin
        n_fail++; $display("FAIL res_alive_%0d: got %b expected 1", i, reservation_valid_o);
      end
    end
    tick();
    n_checks++;
    if (reservation_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL res_timeout: got %b expected 0", reservation_valid_o);
    end
`else
    repeat (20) tick();
    n_checks++;
    if ({reservation_valid_o, reservation_addr_o} !== {1'b1, 32'h2000}) begin
      n_fail++; $display("FAIL res_persist: got %b %h expected 1 00002000",
                         reservation_valid_o, reservation_addr_o);
    end
`endif
  endtask

  task automatic test_random();
    m_entry_t    mq[$];
    m_entry_t    e;
    iType_e      ops [7] = '{LB, LBU, LH, LHU, LW, ADD, SUB};
    logic        exp_we = 1'b0, exp_spur = 1'b0, exp_ready, ld;
    logic [4:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;
    tick();
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++;
      if (regbank_we_o !== exp_we || spurious_rsp_o !== exp_spur ||
          (exp_we && (regbank_addr_o !== exp_addr || regbank_data_o !== exp_data))) begin
        n_fail++; $display("FAIL rand_wb cyc=%0d: got %b %b %0d %h expected %b %b %0d %h", cyc,
                           regbank_we_o, spurious_rsp_o, regbank_addr_o, regbank_data_o,
                           exp_we, exp_spur, exp_addr, exp_data);
      end
      instr_valid_i = 1'($urandom_range(0, 1));
      instruction_operation_i = ops[$urandom_range(0, 6)];
      rd_i = 5'($urandom_range(0, 31));
      result_i = $urandom;
      if (instruction_operation_i == LH || instruction_operation_i == LHU) result_i[0] = 1'b0;
      mem_rvalid_i = ($urandom_range(0, 9) < 4);
      mem_data_i = $urandom;
      flush_i = ($urandom_range(0, 15) == 0);
      ld = (instruction_operation_i inside {LB, LBU, LH, LHU, LW});
      exp_ready = ld ? (mq.size() < DEPTH || (mem_rvalid_i && mq.size() > 0)) : (mq.size() == 0);
      #1;
      n_checks++;
      if (instr_ready_o !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready cyc=%0d: got %b expected %b", cyc, instr_ready_o, exp_ready);
      end
      exp_we = 1'b0;
      exp_spur = mem_rvalid_i && mq.size() == 0;
      if (mem_rvalid_i && mq.size() > 0) begin
        e = mq.pop_front();
        exp_we = !e.killed && !flush_i && e.rd != 0;
        exp_addr = e.rd;
        exp_data = ref_load(e.op, e.addr, mem_data_i);
      end else if (instr_valid_i && exp_ready && !ld) begin
        exp_we = !flush_i && rd_i != 0;
        exp_addr = rd_i;
        exp_data = result_i;
      end
      if (instr_valid_i && exp_ready && ld)
        mq.push_back('{op: instruction_operation_i, rd: rd_i, addr: result_i, killed: 1'b0});
      if (flush_i) foreach (mq[i]) mq[i].killed = 1'b1;
      tick();
    end
    instr_valid_i = 1'b0; mem_rvalid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    repeat (DEPTH) respond(32'h0);
    issue(LW, 5'd13, 32'h500);
    issue(LW, 5'd14, 32'h504);
    respond(32'h7777_7777);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({instr_ready_o, regbank_we_o, regbank_addr_o, regbank_data_o, reservation_valid_o,
         reservation_addr_o, spurious_rsp_o} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %b %b %0d %h %b %h %b expected all 0",
                         instr_ready_o, regbank_we_o, regbank_addr_o, regbank_data_o,
                         reservation_valid_o, reservation_addr_o, spurious_rsp_o);
    end
    tick();
    reset_n = 1'b1;
    respond(32'h1);
    n_checks++;
    if ({spurious_rsp_o, regbank_we_o} !== 2'b10) begin
      n_fail++; $display("FAIL reset_mid_empty: got %b expected 10", {spurious_rsp_o, regbank_we_o});
    end
  endtask

  initial begin
    test_reset();
    test_align();
    test_full();
    test_order();
    test_flush();
    test_spurious();
    test_reservation();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
